// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: decodes a multiplexed 4-digit 7-segment scan into a confirmed binary/BCD score.
// A frame is scanned units first; a value is published only after CONFIRM identical frames.
module seg_scan_decoder #(
    parameter int CONFIRM = 2
) (
    input  logic        clk_2ms,
    input  logic        rst,
    input  logic [10:0] display_led,
    output logic [13:0] score,
    output logic [15:0] bcd,
    output logic        score_valid,
    output logic        frame_err,
    output logic        locked
);
    typedef enum logic [1:0] {HUNT, GOT0, GOT1, GOT2} state_t;
    state_t state, state_n;
    logic [3:0] d0, d1, d2, d0_n, d1_n, d2_n;
    logic [13:0] prev, prev_n, score_n, cand;
    logic [15:0] bcd_n;
    logic [1:0] cnt, cnt_n, cnt_inc;
    logic confirmed, confirmed_n, sv_n, fe_n, locked_n;
    logic [3:0] sel, dig;
    logic seg_ok, idle, units_ok, match;

    always_comb begin
        seg_ok = 1'b1;
        case (display_led[6:0])
            7'b1111110: dig = 4'd0;
            7'b0110000: dig = 4'd1;
            7'b1101101: dig = 4'd2;
            7'b1111001: dig = 4'd3;
            7'b0110011: dig = 4'd4;
            7'b1011011: dig = 4'd5;
            7'b1011111: dig = 4'd6;
            7'b1110000: dig = 4'd7;
            7'b1111111: dig = 4'd8;
            7'b1111011: dig = 4'd9;
            default: begin
                dig = 4'd0;
                seg_ok = 1'b0;
            end
        endcase
    end

    assign sel      = display_led[10:7];
    assign idle     = display_led == 11'b1111_0111111;
    assign units_ok = sel == 4'b0001 && seg_ok;
    // The expected select is one-hot, shifted by how many digits are already held.
    assign match    = sel == (4'b0001 << state) && seg_ok;
    assign cand     = 14'(dig) * 14'd1000 + 14'(d2) * 14'd100 + 14'(d1) * 14'd10 + 14'(d0);
    assign cnt_inc  = cnt == 2'(CONFIRM) ? cnt : cnt + 2'd1;

    always_comb begin
        state_n     = state;
        d0_n        = d0;
        d1_n        = d1;
        d2_n        = d2;
        prev_n      = prev;
        cnt_n       = cnt;
        score_n     = score;
        bcd_n       = bcd;
        confirmed_n = confirmed;
        sv_n        = 1'b0;
        fe_n        = 1'b0;
        locked_n    = locked;
        if (idle) begin
            state_n  = HUNT;
            locked_n = 1'b0;
        end else if (match) begin
            state_n = state_t'(state + 2'd1);
            d0_n    = state == HUNT ? dig : d0;
            d1_n    = state == GOT0 ? dig : d1;
            d2_n    = state == GOT1 ? dig : d2;
            if (state == GOT2) begin
                locked_n = 1'b1;
                prev_n   = cand;
                cnt_n    = cand == prev ? cnt_inc : 2'd1;
                if (cnt_n == 2'(CONFIRM) && (cand != score || !confirmed)) begin
                    score_n     = cand;
                    bcd_n       = {dig, d2, d1, d0};
                    sv_n        = 1'b1;
                    confirmed_n = 1'b1;
                end
            end
        end else if (state != HUNT) begin
            fe_n     = 1'b1;
            locked_n = 1'b0;
            cnt_n    = 2'd0;
            state_n  = units_ok ? GOT0 : HUNT;
            d0_n     = units_ok ? dig : d0;
        end
    end

    always_ff @(posedge clk_2ms or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            d0          <= '0;
            d1          <= '0;
            d2          <= '0;
            prev        <= '0;
            cnt         <= '0;
            score       <= '0;
            bcd         <= '0;
            confirmed   <= 1'b0;
            score_valid <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
        end else begin
            state       <= state_n;
            d0          <= d0_n;
            d1          <= d1_n;
            d2          <= d2_n;
            prev        <= prev_n;
            cnt         <= cnt_n;
            score       <= score_n;
            bcd         <= bcd_n;
            confirmed   <= confirmed_n;
            score_valid <= sv_n;
            frame_err   <= fe_n;
            locked      <= locked_n;
        end
    end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scenarios for seg_scan_decoder with CONFIRM=2.
module tb_seg_scan_decoder;
    logic        clk_2ms = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] display_led = '0;
    logic [13:0] score;
    logic [15:0] bcd;
    logic        score_valid, frame_err, locked;
    int asserts = 0, fails = 0, sv_seen = 0, fe_seen = 0;

    seg_scan_decoder #(.CONFIRM(2)) dut (
        .clk_2ms(clk_2ms), .rst(rst), .display_led(display_led),
        .score(score), .bcd(bcd), .score_valid(score_valid),
        .frame_err(frame_err), .locked(locked)
    );

    always #5 clk_2ms = ~clk_2ms;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: seg = 7'b1111110;
            1: seg = 7'b0110000;
            2: seg = 7'b1101101;
            3: seg = 7'b1111001;
            4: seg = 7'b0110011;
            5: seg = 7'b1011011;
            6: seg = 7'b1011111;
            7: seg = 7'b1110000;
            8: seg = 7'b1111111;
            default: seg = 7'b1111011;
        endcase
    endfunction

    task automatic word(input logic [3:0] s, input logic [6:0] g);
        @(negedge clk_2ms);
        display_led = {s, g};
        @(posedge clk_2ms);
        #1;
        sv_seen += int'(score_valid);
        fe_seen += int'(frame_err);
    endtask

    task automatic frame(input int t, input int h, input int te, input int u);
        word(4'b0001, seg(u));
        word(4'b0010, seg(te));
        word(4'b0100, seg(h));
        word(4'b1000, seg(t));
    endtask

    task automatic test_reset;
        rst = 1'b1;
        display_led = '0;
        repeat (3) @(posedge clk_2ms);
        #1;
        asserts += 5;
        if (score !== 14'd0) begin fails++; $display("FAIL reset_score: got %0d want 0", score); end
        if (bcd !== 16'h0) begin fails++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
        if (score_valid !== 1'b0) begin fails++; $display("FAIL reset_sv: got %b want 0", score_valid); end
        if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_fe: got %b want 0", frame_err); end
        if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked); end
        @(negedge clk_2ms);
        rst = 1'b0;
    endtask

    task automatic test_confirm;
        sv_seen = 0;
        frame(1, 2, 3, 4);
        asserts += 2;
        if (sv_seen !== 0) begin fails++; $display("FAIL confirm_f1_sv: got %0d pulses want 0", sv_seen); end
        if (locked !== 1'b1) begin fails++; $display("FAIL confirm_f1_locked: got %b want 1", locked); end
        frame(1, 2, 3, 4);
        asserts += 4;
        if (score_valid !== 1'b1) begin fails++; $display("FAIL confirm_f2_sv: got %b want 1", score_valid); end
        if (score !== 14'd1234) begin fails++; $display("FAIL confirm_score: got %0d want 1234", score); end
        if (bcd !== 16'h1234) begin fails++; $display("FAIL confirm_bcd: got %h want 1234", bcd); end
        if (sv_seen !== 1) begin fails++; $display("FAIL confirm_f2_count: got %0d pulses want 1", sv_seen); end
        sv_seen = 0;
        frame(1, 2, 3, 4);
        frame(1, 2, 3, 4);
        asserts += 2;
        if (sv_seen !== 0) begin fails++; $display("FAIL confirm_repeat_sv: got %0d pulses want 0", sv_seen); end
        if (locked !== 1'b1) begin fails++; $display("FAIL confirm_repeat_locked: got %b want 1", locked); end
    endtask

    task automatic test_change;
        sv_seen = 0;
        fe_seen = 0;
        frame(0, 0, 4, 2);
        frame(0, 0, 4, 2);
        asserts += 2;
        if (sv_seen !== 1) begin fails++; $display("FAIL change_42_sv: got %0d pulses want 1", sv_seen); end
        if (score !== 14'd42) begin fails++; $display("FAIL change_42_score: got %0d want 42", score); end
        sv_seen = 0;
        frame(0, 0, 4, 3);
        asserts += 2;
        if (sv_seen !== 0) begin fails++; $display("FAIL change_43_f1_sv: got %0d pulses want 0", sv_seen); end
        if (score !== 14'd42) begin fails++; $display("FAIL change_43_f1_hold: got %0d want 42", score); end
        frame(0, 0, 4, 3);
        asserts += 4;
        if (sv_seen !== 1) begin fails++; $display("FAIL change_43_sv: got %0d pulses want 1", sv_seen); end
        if (score !== 14'd43) begin fails++; $display("FAIL change_43_score: got %0d want 43", score); end
        if (bcd !== 16'h0043) begin fails++; $display("FAIL change_43_bcd: got %h want 0043", bcd); end
        if (fe_seen !== 0) begin fails++; $display("FAIL change_fe: got %0d errors want 0", fe_seen); end
    endtask

    task automatic test_skip;
        fe_seen = 0;
        word(4'b0001, seg(5));
        word(4'b0010, seg(6));
        asserts++;
        if (fe_seen !== 0) begin fails++; $display("FAIL skip_early_fe: got %0d errors want 0", fe_seen); end
        word(4'b1000, seg(7));
        asserts += 3;
        if (frame_err !== 1'b1) begin fails++; $display("FAIL skip_fe: got %b want 1", frame_err); end
        if (locked !== 1'b0) begin fails++; $display("FAIL skip_locked: got %b want 0", locked); end
        if (score !== 14'd43) begin fails++; $display("FAIL skip_hold: got %0d want 43", score); end
        sv_seen = 0;
        frame(5, 6, 7, 8);
        asserts++;
        if (sv_seen !== 0) begin fails++; $display("FAIL skip_f1_sv: got %0d pulses want 0", sv_seen); end
        frame(5, 6, 7, 8);
        asserts += 2;
        if (score_valid !== 1'b1) begin fails++; $display("FAIL skip_f2_sv: got %b want 1", score_valid); end
        if (score !== 14'd5678) begin fails++; $display("FAIL skip_score: got %0d want 5678", score); end
    endtask

    task automatic test_bad_seg;
        fe_seen = 0;
        word(4'b0001, seg(1));
        word(4'b0010, 7'b0000001);
        asserts++;
        if (frame_err !== 1'b1) begin fails++; $display("FAIL badseg_fe: got %b want 1", frame_err); end
        fe_seen = 0;
        sv_seen = 0;
        frame(8, 7, 6, 5);
        asserts += 3;
        if (fe_seen !== 0) begin fails++; $display("FAIL badseg_after_fe: got %0d errors want 0", fe_seen); end
        if (locked !== 1'b1) begin fails++; $display("FAIL badseg_locked: got %b want 1", locked); end
        if (sv_seen !== 0) begin fails++; $display("FAIL badseg_sv: got %0d pulses want 0", sv_seen); end
    endtask

    task automatic test_resync;
        fe_seen = 0;
        sv_seen = 0;
        word(4'b0001, seg(3));
        word(4'b0010, seg(3));
        word(4'b0001, seg(5));
        asserts += 2;
        if (frame_err !== 1'b1) begin fails++; $display("FAIL resync_fe: got %b want 1", frame_err); end
        if (locked !== 1'b0) begin fails++; $display("FAIL resync_locked_low: got %b want 0", locked); end
        word(4'b0010, seg(6));
        word(4'b0100, seg(7));
        word(4'b1000, seg(8));
        asserts += 3;
        if (fe_seen !== 1) begin fails++; $display("FAIL resync_fe_count: got %0d errors want 1", fe_seen); end
        if (locked !== 1'b1) begin fails++; $display("FAIL resync_locked: got %b want 1", locked); end
        if (sv_seen !== 0) begin fails++; $display("FAIL resync_count_cleared: got %0d pulses want 0", sv_seen); end
        frame(8, 7, 6, 5);
        asserts += 2;
        if (sv_seen !== 1) begin fails++; $display("FAIL resync_confirm_sv: got %0d pulses want 1", sv_seen); end
        if (score !== 14'd8765) begin fails++; $display("FAIL resync_score: got %0d want 8765", score); end
    endtask

    task automatic test_idle;
        fe_seen = 0;
        sv_seen = 0;
        word(4'b0001, seg(9));
        word(4'b0010, seg(9));
        word(4'b1111, 7'b0111111);
        asserts += 2;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL idle_fe: got %b want 0", frame_err); end
        if (locked !== 1'b0) begin fails++; $display("FAIL idle_locked: got %b want 0", locked); end
        word(4'b0100, seg(9));
        word(4'b1000, seg(9));
        asserts += 4;
        if (fe_seen !== 0) begin fails++; $display("FAIL idle_drop_fe: got %0d errors want 0", fe_seen); end
        if (locked !== 1'b0) begin fails++; $display("FAIL idle_drop_locked: got %b want 0", locked); end
        if (sv_seen !== 0) begin fails++; $display("FAIL idle_drop_sv: got %0d pulses want 0", sv_seen); end
        if (score !== 14'd8765) begin fails++; $display("FAIL idle_hold: got %0d want 8765", score); end
    endtask

    task automatic test_reset_mid;
        frame(9, 9, 9, 9);
        frame(9, 9, 9, 9);
        asserts++;
        if (score !== 14'd9999) begin fails++; $display("FAIL rmid_pre_score: got %0d want 9999", score); end
        word(4'b0001, seg(1));
        word(4'b0010, seg(1));
        #2 rst = 1'b1;
        display_led = '0;
        #1;
        asserts += 4;
        if (score !== 14'd0) begin fails++; $display("FAIL rmid_score: got %0d want 0", score); end
        if (bcd !== 16'h0) begin fails++; $display("FAIL rmid_bcd: got %h want 0000", bcd); end
        if (locked !== 1'b0) begin fails++; $display("FAIL rmid_locked: got %b want 0", locked); end
        if ((score_valid | frame_err) !== 1'b0) begin fails++; $display("FAIL rmid_pulses: got sv=%b fe=%b want 0", score_valid, frame_err); end
        repeat (2) @(negedge clk_2ms);
        rst = 1'b0;
        fe_seen = 0;
        sv_seen = 0;
        word(4'b0100, seg(1));
        word(4'b1000, seg(1));
        frame(0, 0, 0, 0);
        asserts += 2;
        if (fe_seen !== 0) begin fails++; $display("FAIL rmid_restart_fe: got %0d errors want 0", fe_seen); end
        if (sv_seen !== 0) begin fails++; $display("FAIL rmid_f1_sv: got %0d pulses want 0", sv_seen); end
        frame(0, 0, 0, 0);
        asserts += 3;
        if (score_valid !== 1'b1) begin fails++; $display("FAIL rmid_zero_sv: got %b want 1", score_valid); end
        if (score !== 14'd0) begin fails++; $display("FAIL rmid_zero_score: got %0d want 0", score); end
        if (locked !== 1'b1) begin fails++; $display("FAIL rmid_zero_locked: got %b want 1", locked); end
    endtask

    initial begin
        test_reset;
        test_confirm;
        test_change;
        test_skip;
        test_bad_seg;
        test_resync;
        test_idle;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
